// File: rtl/sspis_pkg.sv
// sspis_pkg: shared types and constants for the SPI target byte engine.
package sspis_pkg;

    typedef enum logic [0:0] {
        SSPIS_IDLE,
        SSPIS_ACTIVE
    } sspis_state_e;

    localparam logic [7:0]  SSPIS_TX_FILL   = 8'hFF;
    localparam int unsigned SSPIS_BIT_CNT_W = 3;

    // Bit presented on MISO for a given shift register content and bit order.
    function automatic logic sspis_out_bit(input logic [7:0] v, input logic lsb_first);
        return lsb_first ? v[0] : v[7];
    endfunction

endpackage

// File: rtl/sspis_if.sv
// sspis_if: host-side byte handshake of the SPI target (tx buffer, rx byte, status).
interface sspis_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_udr;
    logic       busy;

    // Core side
    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, rx_data, rx_valid, tx_udr, busy
    );

    // Register block side
    modport master (
        output tx_data, tx_valid,
        input  tx_ready, rx_data, rx_valid, tx_udr, busy
    );
endinterface

// File: rtl/sspis_sync.sv
// sspis_sync: multi-flop synchronizer plus one history flop; flags rising/falling edges.
module sspis_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic rst_val_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Synchronizer chain and history flop, reset to the pin's idle level.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{rst_val_i}};
            hist_q <= rst_val_i;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign q_o    = sync_q[SYNC_STAGES-1];
    assign rise_o = q_o & ~hist_q;
    assign fall_o = ~q_o & hist_q;

endmodule

// File: rtl/sspis_core.sv
// sspis_core: SPI target byte engine. Oversamples SCK/SSN/MOSI, shifts bytes in and out
// and trades them with the host through sspis_if.
// Optional: define SSPIS_LSB_FIRST_EN to add cfg_lsb_first (LSB-first shifting).
module sspis_core
    import sspis_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic cfg_cpol,
    input  logic cfg_cpha,
`ifdef SSPIS_LSB_FIRST_EN
    input  logic cfg_lsb_first,
`endif
    input  logic sclk,
    input  logic ssn,
    input  logic sdin,
    output logic sdout,
    output logic sdout_oen,
    sspis_if.slave host
);

    logic sclk_s, sclk_rise, sclk_fall;
    logic ssn_s, ssn_rise, ssn_fall;
    logic sdin_s, sdin_rise, sdin_fall;
    logic lsb_sel;

`ifdef SSPIS_LSB_FIRST_EN
    assign lsb_sel = cfg_lsb_first;
`else
    assign lsb_sel = 1'b0;
`endif

    sspis_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .reset_n(reset_n), .rst_val_i(cfg_cpol), .d_i(sclk),
        .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    sspis_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ssn (
        .clk(clk), .reset_n(reset_n), .rst_val_i(1'b1), .d_i(ssn),
        .q_o(ssn_s), .rise_o(ssn_rise), .fall_o(ssn_fall)
    );
    sspis_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdin (
        .clk(clk), .reset_n(reset_n), .rst_val_i(1'b0), .d_i(sdin),
        .q_o(sdin_s), .rise_o(sdin_rise), .fall_o(sdin_fall)
    );

    sspis_state_e               state_q, state_d;
    logic                       cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
    logic [SSPIS_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]                 shreg_q, shreg_d, rx_sh_q, rx_sh_d;
    logic [7:0]                 rx_data_q, rx_data_d, tx_buf_q, tx_buf_d;
    logic                       sdout_q, sdout_d, oen_q, oen_d, busy_q, busy_d;
    logic                       rx_valid_q, rx_valid_d, tx_udr_q, tx_udr_d;
    logic                       tx_full_q, tx_full_d;
    // hold: next shift edge drives the freshly loaded MSB/LSB instead of shifting.
    logic                       hold_q, hold_d;
    // udr_pend: buffer was empty at end-of-byte reload; report once the next byte starts.
    logic                       udr_pend_q, udr_pend_d;
    logic                       drain;
    logic [7:0]                 load_val;
    logic                       sclk_edge, leading, sample_edge, shift_edge;

    assign load_val    = tx_full_q ? tx_buf_q : SSPIS_TX_FILL;
    assign sclk_edge   = sclk_rise | sclk_fall;
    assign leading     = sclk_edge & (sclk_s != cpol_q);
    assign sample_edge = cpha_q ? (sclk_edge & ~leading) : leading;
    assign shift_edge  = cpha_q ? leading : (sclk_edge & ~leading);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= SSPIS_IDLE;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            bit_cnt_q  <= '0;
            shreg_q    <= SSPIS_TX_FILL;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            tx_buf_q   <= '0;
            sdout_q    <= 1'b1;
            oen_q      <= 1'b1;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_udr_q   <= 1'b0;
            tx_full_q  <= 1'b0;
            hold_q     <= 1'b0;
            udr_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            lsb_q      <= lsb_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            tx_buf_q   <= tx_buf_d;
            sdout_q    <= sdout_d;
            oen_q      <= oen_d;
            busy_q     <= busy_d;
            rx_valid_q <= rx_valid_d;
            tx_udr_q   <= tx_udr_d;
            tx_full_q  <= tx_full_d;
            hold_q     <= hold_d;
            udr_pend_q <= udr_pend_d;
        end
    end

    // FSM next state, bit engine and tx buffer bookkeeping.
    always_comb begin
        state_d    = state_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        tx_buf_d   = tx_buf_q;
        sdout_d    = sdout_q;
        oen_d      = oen_q;
        busy_d     = busy_q;
        tx_full_d  = tx_full_q;
        hold_d     = hold_q;
        udr_pend_d = udr_pend_q;
        rx_valid_d = 1'b0;
        tx_udr_d   = 1'b0;
        drain      = 1'b0;

        unique case (state_q)
            SSPIS_IDLE: begin
                if (ssn_fall) begin
                    state_d    = SSPIS_ACTIVE;
                    cpol_d     = cfg_cpol;
                    cpha_d     = cfg_cpha;
                    lsb_d      = lsb_sel;
                    bit_cnt_d  = '0;
                    rx_sh_d    = '0;
                    busy_d     = 1'b1;
                    oen_d      = 1'b0;
                    shreg_d    = load_val;
                    sdout_d    = sspis_out_bit(load_val, lsb_sel);
                    tx_udr_d   = ~tx_full_q;
                    drain      = 1'b1;
                    hold_d     = cfg_cpha;
                    udr_pend_d = 1'b0;
                end
            end
            SSPIS_ACTIVE: begin
                if (ssn_s) begin
                    state_d    = SSPIS_IDLE;
                    bit_cnt_d  = '0;
                    rx_sh_d    = '0;
                    oen_d      = 1'b1;
                    sdout_d    = 1'b1;
                    busy_d     = 1'b0;
                    hold_d     = 1'b0;
                    udr_pend_d = 1'b0;
                end else begin
                    if (leading && udr_pend_q) begin
                        tx_udr_d   = 1'b1;
                        udr_pend_d = 1'b0;
                    end
                    if (sample_edge) begin
                        rx_sh_d   = lsb_q ? {sdin_s, rx_sh_q[7:1]} : {rx_sh_q[6:0], sdin_s};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == '1) begin
                            rx_data_d  = rx_sh_d;
                            rx_valid_d = 1'b1;
                            shreg_d    = load_val;
                            drain      = 1'b1;
                            udr_pend_d = ~tx_full_q;
                            hold_d     = 1'b1;
                        end
                    end else if (shift_edge) begin
                        if (hold_q) begin
                            sdout_d = sspis_out_bit(shreg_q, lsb_q);
                            hold_d  = 1'b0;
                        end else begin
                            shreg_d = lsb_q ? {1'b1, shreg_q[7:1]} : {shreg_q[6:0], 1'b1};
                            sdout_d = sspis_out_bit(shreg_d, lsb_q);
                        end
                    end
                end
            end
            default: state_d = SSPIS_IDLE;
        endcase

        // Drain first so a same-cycle write lands after the old byte is taken.
        if (drain) tx_full_d = 1'b0;
        if (host.tx_valid && !tx_full_q) begin
            tx_buf_d  = host.tx_data;
            tx_full_d = 1'b1;
        end
    end

    assign sdout         = sdout_q;
    assign sdout_oen     = oen_q;
    assign host.tx_ready = ~tx_full_q;
    assign host.rx_data  = rx_data_q;
    assign host.rx_valid = rx_valid_q;
    assign host.tx_udr   = tx_udr_q;
    assign host.busy     = busy_q;

endmodule
